alu_result_collector: RTL and testbench
=======================================

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 SHALL have parameter N_TREE, default 2, number of ALU trees feeding the block.
REQ-002 SHALL have parameter N_ALU_PER_TREE, default 7, ALUs per tree; N_SLOT = N_TREE*N_ALU_PER_TREE; slot index = tree*N_ALU_PER_TREE + alu.
REQ-003 SHALL have parameter WORD_W, default 32, result word width; SLOT_W = clog2(N_SLOT).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 en  in  1  global enable, same meaning as the ALU enable.
REQ-007 cap_vld  in  1  capture request for the current tree outputs.
REQ-008 cap_rdy  out  1  block can accept a capture this cycle.
REQ-009 cap_mask  in  N_SLOT  slots to be written back.
REQ-010 res_vld  in  N_SLOT  per-slot ALU output valid from the processing block.
REQ-011 res_data  in  N_SLOT*WORD_W  per-slot ALU output words, slot i at bits [i*WORD_W +: WORD_W].
REQ-012 wb_vld  out  1  write-back word valid.
REQ-013 wb_rdy  in  1  write-back sink ready.
REQ-014 wb_slot  out  SLOT_W  slot index of wb_data.
REQ-015 wb_data  out  WORD_W  write-back word.
REQ-016 busy  out  1  high whenever state is DRAIN.
REQ-017 drop_err  out  1  sticky: a masked slot was not valid at capture.

Function
REQ-018 SHALL implement FSM states IDLE and DRAIN, plus registers pending[N_SLOT] and snap[N_SLOT][WORD_W].
REQ-019 Capture fires when cap_vld & cap_rdy & en; pending <= cap_mask & res_vld; snap[i] <= res_data slot i for every slot set in the new pending; other snap entries hold.
REQ-020 On capture, drop_err SHALL set if (cap_mask & ~res_vld) != 0; drop_err clears only on reset.
REQ-021 Capture with new pending == 0: state stays/returns IDLE, no write-back issued.
REQ-022 Capture with new pending != 0: state DRAIN next cycle; first wb_vld exactly 1 cycle after capture.
REQ-023 wb_vld = (state==DRAIN) & en; wb_slot = index of lowest set bit of pending; wb_data = snap[wb_slot]; all three driven from registers only (no input-to-output path except via en).
REQ-024 On wb_vld & wb_rdy, the lowest set bit of pending SHALL clear; wb_slot/wb_data SHALL hold stable while wb_vld & ~wb_rdy.
REQ-025 When the last pending bit is accepted: state -> IDLE unless a capture fires in the same cycle (REQ-026).
REQ-026 cap_rdy = en & (state==IDLE | (state==DRAIN & popcount(pending)==1 & wb_rdy)); simultaneous last-accept and capture SHALL load new pending/snap with no idle cycle.
REQ-027 en low: FSM, pending, snap, drop_err SHALL hold; no capture, no accept.
REQ-028 Throughput: k masked-valid slots drain in k cycles with wb_rdy held high; back-to-back captures sustain one word per cycle.
REQ-029 cap_vld while cap_rdy low SHALL be ignored (no capture, no error).

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, pending 0, snap 0, drop_err 0; hence wb_vld 0, wb_slot 0, wb_data 0, busy 0, cap_rdy = en.
REQ-031 Reset asserted mid-DRAIN SHALL discard all pending words; first capture allowed on the first enabled cycle after rst deasserts.

Verification
REQ-032 Defaults; cap_mask=0x0005, res_vld=0x3FFF, slot0=0xA, slot2=0xB, wb_rdy=1 -> wb (0,0xA) at cycle+1, (2,0xB) at cycle+2, cap_rdy high at cycle+2, busy 0 at cycle+3.
REQ-033 cap_mask=0x0003, res_vld=0x0001 -> single wb (0,data0), drop_err=1 and stays 1 across later clean captures.
REQ-034 Capture mask 0x0006, wb_rdy low 3 cycles then high -> wb (1,d1) held stable 3 cycles, then (2,d2); no loss or duplicate.
REQ-035 Back-to-back: capture 0x0001 then capture 0x0100 on the cycle slot0 is accepted -> wb (0,·) then (8,·) on consecutive cycles, busy never drops.
REQ-036 rst low mid-DRAIN with 3 bits pending -> outputs zero immediately (async), no further wb_vld after release; en low during DRAIN -> wb_vld 0, state frozen, resumes identically.

Source files
------------

// File: rtl/alu_result_collector.sv
// alu_result_collector: snapshots the masked, valid ALU slot results on capture and
// drains them lowest-slot-first as write-back words, one per accepted cycle.
module alu_result_collector #(
  parameter int N_TREE = 2,
  parameter int N_ALU_PER_TREE = 7,
  parameter int WORD_W = 32,
  localparam int N_SLOT = N_TREE * N_ALU_PER_TREE,
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_cap_vld,
  output logic                     o_cap_rdy,
  input  logic [N_SLOT-1:0]        i_cap_mask,
  input  logic [N_SLOT-1:0]        i_res_vld,
  input  logic [N_SLOT*WORD_W-1:0] i_res_data,
  output logic                     o_wb_vld,
  input  logic                     i_wb_rdy,
  output logic [SLOT_W-1:0]        o_wb_slot,
  output logic [WORD_W-1:0]        o_wb_data,
  output logic                     o_busy,
  output logic                     o_drop_err
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  logic [N_SLOT-1:0] r_pending, w_pending_nxt, w_new, w_low;
  logic [N_SLOT-1:0][WORD_W-1:0] r_snap;
  logic r_drop_err;
  logic [SLOT_W-1:0] w_slot;
  logic w_one, w_cap, w_acc;

  assign w_new = i_cap_mask & i_res_vld;
  assign w_low = r_pending & (~r_pending + N_SLOT'(1));
  // Exactly one bit left (pending is never zero while draining).
  assign w_one = (r_pending & (r_pending - N_SLOT'(1))) == '0;
  assign o_cap_rdy = i_en & ((r_state == IDLE) | ((r_state == DRAIN) & w_one & i_wb_rdy));
  assign o_wb_vld = (r_state == DRAIN) & i_en;
  assign w_cap = i_cap_vld & o_cap_rdy;
  assign w_acc = o_wb_vld & i_wb_rdy;
  assign o_wb_slot = w_slot;
  assign o_wb_data = r_snap[w_slot];
  assign o_busy = r_state == DRAIN;
  assign o_drop_err = r_drop_err;

  always_comb begin
    w_slot = '0;
    for (int i = N_SLOT - 1; i >= 0; i--)
      if (r_pending[i]) w_slot = SLOT_W'(i);
  end

  always_comb begin
    w_pending_nxt = w_cap ? w_new : w_acc ? (r_pending & ~w_low) : r_pending;
    w_state_nxt = w_cap ? ((|w_new) ? DRAIN : IDLE) : (w_acc & w_one) ? IDLE : r_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pending <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_drop_err <= r_drop_err | (w_cap & |(i_cap_mask & ~i_res_vld));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_snap <= '0;
    else
      for (int i = 0; i < N_SLOT; i++)
        if (w_cap & w_new[i]) r_snap[i] <= i_res_data[i*WORD_W +: WORD_W];
  end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed and random stimulus checked every cycle against a
// queue-based model of the outstanding write-back words.
module tb_alu_result_collector;
  localparam int N_SLOT = 14;
  localparam int W = 32;

  logic clk, rst_n, en, cap_vld, cap_rdy, wb_vld, wb_rdy, busy, drop;
  logic [N_SLOT-1:0] cap_mask, res_vld;
  logic [N_SLOT*W-1:0] res_data;
  logic [3:0] wb_slot;
  logic [W-1:0] wb_data;
  int tests = 0;
  int fails = 0;

  alu_result_collector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cap_vld(cap_vld), .o_cap_rdy(cap_rdy),
    .i_cap_mask(cap_mask), .i_res_vld(res_vld), .i_res_data(res_data),
    .o_wb_vld(wb_vld), .i_wb_rdy(wb_rdy), .o_wb_slot(wb_slot), .o_wb_data(wb_data),
    .o_busy(busy), .o_drop_err(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int slot;
    logic [W-1:0] data;
  } wb_t;
  wb_t q[$];
  logic m_drop = 1'b0;

  function automatic bit m_rdy();
    return en && (q.size() == 0 || (q.size() == 1 && wb_rdy));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_drop <= 1'b0;
    end else if (en) begin
      if (cap_vld && m_rdy()) begin
        q.delete();
        for (int i = 0; i < N_SLOT; i++)
          if (cap_mask[i] && res_vld[i]) q.push_back('{i, res_data[i*W +: W]});
        if ((cap_mask & ~res_vld) != '0) m_drop <= 1'b1;
      end else if (q.size() > 0 && wb_rdy) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("cap_rdy", cap_rdy, m_rdy());
    chk("wb_vld", wb_vld, en && q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("drop_err", drop, m_drop);
    if (q.size() > 0) begin
      chk("wb_slot", wb_slot, q[0].slot);
      chk("wb_data", wb_data, q[0].data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic win();
    @(negedge clk);
  endtask

  task automatic cap(input logic [N_SLOT-1:0] m, input logic [N_SLOT-1:0] v);
    cap_vld = 1'b1;
    cap_mask = m;
    res_vld = v;
    for (int i = 0; i < N_SLOT; i++) res_data[i*W +: W] = $urandom;
  endtask

  logic [W-1:0] d0, d1, d2, d3, d8;

  initial begin
    rst_n = 1'b0; en = 1'b1; cap_vld = 1'b0; cap_mask = '0; res_vld = '0;
    res_data = '0; wb_rdy = 1'b1;
    #2;
    chk("rst_cap_rdy", cap_rdy, 1);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_wb_data", wb_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // Two-slot capture drains in consecutive cycles.
    cap(14'h0005, 14'h3FFF);
    res_data[0 +: W] = 32'hA;
    res_data[2*W +: W] = 32'hB;
    tick(); cap_vld = 1'b0;
    win(); chk("c1_vld", wb_vld, 1); chk("c1_slot", wb_slot, 0); chk("c1_data", wb_data, 32'hA);
    tick();
    win(); chk("c2_slot", wb_slot, 2); chk("c2_data", wb_data, 32'hB); chk("c2_rdy", cap_rdy, 1);
    tick();
    win(); chk("c3_busy", busy, 0);
    tick();
    // Masked slot not valid sets the sticky error.
    cap(14'h0003, 14'h0001);
    d0 = res_data[0 +: W];
    tick(); cap_vld = 1'b0;
    win(); chk("drop_slot", wb_slot, 0); chk("drop_data", wb_data, d0);
    tick();
    win(); chk("drop_busy", busy, 0); chk("drop_set", drop, 1);
    tick();
    cap(14'h0010, 14'h3FFF);
    tick(); cap_vld = 1'b0;
    tick(); tick();
    win(); chk("drop_sticky", drop, 1);
    tick();
    // Backpressure holds the presented word.
    cap(14'h0006, 14'h3FFF);
    d1 = res_data[W +: W];
    d2 = res_data[2*W +: W];
    wb_rdy = 1'b0;
    tick(); cap_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      win(); chk("hold_slot", wb_slot, 1); chk("hold_data", wb_data, d1);
      tick();
    end
    wb_rdy = 1'b1;
    tick();
    win(); chk("bp_slot2", wb_slot, 2); chk("bp_data2", wb_data, d2);
    tick();
    win(); chk("bp_idle", busy, 0);
    tick();
    // Capture on the last accept keeps the drain seamless.
    cap(14'h0001, 14'h0001);
    tick();
    cap(14'h0100, 14'h0100);
    d8 = res_data[8*W +: W];
    win(); chk("b2b_slot0", wb_slot, 0); chk("b2b_rdy", cap_rdy, 1); chk("b2b_busy0", busy, 1);
    tick(); cap_vld = 1'b0;
    win(); chk("b2b_slot8", wb_slot, 8); chk("b2b_data8", wb_data, d8); chk("b2b_busy1", busy, 1);
    tick(); tick();
    // Async reset mid-drain.
    cap(14'h0007, 14'h0007);
    wb_rdy = 1'b0;
    tick(); cap_vld = 1'b0;
    win(); chk("pre_rst_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_vld", wb_vld, 0); chk("arst_slot", wb_slot, 0); chk("arst_data", wb_data, 0);
    chk("arst_busy", busy, 0); chk("arst_drop", drop, 0); chk("arst_rdy", cap_rdy, 1);
    tick(); rst_n = 1'b1; wb_rdy = 1'b1;
    win(); chk("post_rst_vld", wb_vld, 0);
    tick();
    // Enable low freezes the drain and blocks captures.
    cap(14'h000B, 14'h000B);
    d0 = res_data[0 +: W];
    d1 = res_data[W +: W];
    d3 = res_data[3*W +: W];
    tick();
    en = 1'b0; cap_mask = 14'h3FFF; res_vld = 14'h3FFF;
    win(); chk("en0_vld", wb_vld, 0); chk("en0_rdy", cap_rdy, 0); chk("en0_busy", busy, 1);
    tick();
    win(); chk("en0_vld2", wb_vld, 0);
    tick(); en = 1'b1; cap_vld = 1'b0;
    win(); chk("en1_slot0", wb_slot, 0); chk("en1_data0", wb_data, d0);
    tick();
    win(); chk("en1_slot1", wb_slot, 1); chk("en1_data1", wb_data, d1);
    tick();
    win(); chk("en1_slot3", wb_slot, 3); chk("en1_data3", wb_data, d3);
    tick();
    win(); chk("en1_idle", busy, 0);
    tick();
    // Random traffic against the model.
    repeat (3000) begin
      en = ($urandom % 10) != 0;
      cap_vld = ($urandom % 3) == 0;
      cap_mask = ($urandom % 8 == 0) ? N_SLOT'(1 << ($urandom % N_SLOT)) : N_SLOT'($urandom);
      res_vld = ($urandom % 4 == 0) ? N_SLOT'($urandom) : N_SLOT'($urandom | $urandom);
      wb_rdy = ($urandom % 4) != 0;
      for (int i = 0; i < N_SLOT; i++) res_data[i*W +: W] = $urandom;
      rst_n = ($urandom % 700) != 0;
      tick();
      rst_n = 1'b1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
